// File: rtl/divergence_ctrl.sv
// SIMT divergence controller: tracks the warp active mask and drives the divergence stack.
// Latency: non-divergent split 2 cycles, divergent split 3 cycles, join 3 cycles, error cases 1 cycle.
// Backpressure: cmd_ready drops while a split/join is in flight; POP_WAIT holds until stk_data_vld.
module divergence_ctrl #(
  parameter int NUM_THREADS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [31:0]            cmd_pc,
  input  logic [NUM_THREADS-1:0] cmd_pred,
  output logic [NUM_THREADS-1:0] active_mask,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_push_back,
  output logic                   stk_read_tos,
  output logic [71:0]            stk_data,
  input  logic                   stk_data_vld,
  input  logic [71:0]            stk_data_out,
  input  logic                   stk_full,
  input  logic                   stk_empty
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PUSH_DIV = 2'd1;
  localparam logic [1:0] S_POP_WAIT = 2'd2;

  logic [1:0]             state;
  logic [31:0]            div_pc;      // resume PC of the not-taken group
  logic [NUM_THREADS-1:0] div_mask;    // not-taken threads, pushed second
  logic [NUM_THREADS-1:0] taken_mask;  // mask installed once both pushes are done
  logic                   mask_pend;   // taken_mask waits to be installed in the settle cycle

  logic [NUM_THREADS-1:0] taken;
  logic [NUM_THREADS-1:0] not_taken;
  logic                   divergent;

  // Only the mask field and the is_div/pc fields of a popped entry matter.
  logic [71:0]            unused_stk_data_out;
  assign unused_stk_data_out = stk_data_out;

  // Split outcome for the command currently presented.
  always_comb begin
    taken     = active_mask & cmd_pred;
    not_taken = active_mask & ~cmd_pred;
    divergent = (|taken) && (|not_taken);
  end

  // Stack entry: {is_div, 7'b0, pc, mask zero-extended to 32 bits}.
  function automatic logic [71:0] make_entry(input logic is_div, input logic [31:0] pc,
                                             input logic [NUM_THREADS-1:0] m);
    logic [31:0] m32;
    m32 = '0;
    m32[NUM_THREADS-1:0] = m;
    return {is_div, 7'b0, pc, m32};
  endfunction

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cmd_ready      <= 1'b1;
      active_mask    <= '1;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
      stk_push       <= 1'b0;
      stk_pop        <= 1'b0;
      stk_push_back  <= 1'b0;
      stk_read_tos   <= 1'b0;
      stk_data       <= 72'd0;
      div_pc         <= 32'd0;
      div_mask       <= '0;
      taken_mask     <= '0;
      mask_pend      <= 1'b0;
    end else begin
      // Strobes and the redirect are single-cycle unless re-asserted below.
      stk_push       <= 1'b0;
      stk_pop        <= 1'b0;
      stk_push_back  <= 1'b0;
      stk_read_tos   <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmd_ready) begin
            // Settle cycle after a split: reopen the port, install the taken mask if pending.
            cmd_ready <= 1'b1;
            if (mask_pend) begin
              active_mask <= taken_mask;
              mask_pend   <= 1'b0;
            end
          end else if (cmd_valid) begin
            if (!cmd_op) begin
              if (stk_full) begin
                err_overflow <= 1'b1;
              end else begin
                stk_push  <= 1'b1;
                stk_data  <= make_entry(1'b0, 32'd0, active_mask);
                cmd_ready <= 1'b0;
                if (divergent) begin
                  state      <= S_PUSH_DIV;
                  div_pc     <= cmd_pc + 32'd4;
                  div_mask   <= not_taken;
                  taken_mask <= taken;
                end
              end
            end else begin
              if (stk_empty) begin
                err_underflow <= 1'b1;
              end else begin
                stk_pop   <= 1'b1;
                cmd_ready <= 1'b0;
                state     <= S_POP_WAIT;
              end
            end
          end
        end
        S_PUSH_DIV: begin
          // cmd_ready stays low so IDLE spends one settle cycle before reopening.
          state <= S_IDLE;
          if (stk_full) begin
            err_overflow <= 1'b1;
          end else begin
            stk_push  <= 1'b1;
            stk_data  <= make_entry(1'b1, div_pc, div_mask);
            mask_pend <= 1'b1;
          end
        end
        S_POP_WAIT: begin
          if (stk_data_vld) begin
            active_mask <= stk_data_out[NUM_THREADS-1:0];
            if (stk_data_out[71]) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= stk_data_out[63:32];
            end
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divergence_ctrl.sv
// Bench for divergence_ctrl: stack emulator plus transaction-level timing model.
// Directed scenarios pin the model with literals, then randomized traffic with occasional resets.
// Stack depth is small so overflow and underflow occur naturally.
module tb_divergence_ctrl;
  localparam int NT    = 32;
  localparam int DEPTH = 6;
  localparam int MAXC  = 8192;
  localparam int BIG   = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [31:0]   cmd_pc = 32'd0;
  logic [NT-1:0] cmd_pred = '0;
  logic [NT-1:0] active_mask;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          err_overflow, err_underflow;
  logic          stk_push, stk_pop, stk_push_back, stk_read_tos;
  logic [71:0]   stk_data;
  logic          stk_data_vld = 1'b0;
  logic [71:0]   stk_data_out = 72'd0;
  logic          stk_full = 1'b0;
  logic          stk_empty = 1'b1;

  divergence_ctrl #(.NUM_THREADS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pc(cmd_pc), .cmd_pred(cmd_pred), .active_mask(active_mask),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_push_back(stk_push_back),
    .stk_read_tos(stk_read_tos), .stk_data(stk_data), .stk_data_vld(stk_data_vld),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  int          cyc = 0;
  bit          mdl_on = 1'b0;
  bit          e_push  [MAXC];
  logic [71:0] e_pdat  [MAXC];
  bit          e_pop   [MAXC];
  bit          e_redir [MAXC];
  logic [31:0] e_rpc   [MAXC];
  int          ready_cyc = 0, ov_cyc = BIG, un_cyc = BIG, upd_cyc = -1;
  logic [31:0] upd_val = 32'd0;
  logic [31:0] mdl_mask = '1;
  logic [71:0] mdl_stk[$];

  // ---------------- stack emulator state ----------------
  logic [71:0] emu_q[$];
  bit          vld_pend = 1'b0;
  logic [71:0] pend_dat = 72'd0;
  logic [71:0] push_log[$];
  int          pop_cnt = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic mdl_reset(input int c);
    mdl_mask  = '1;
    ready_cyc = c + 1;
    ov_cyc    = BIG;
    un_cyc    = BIG;
    upd_cyc   = -1;
    mdl_stk.delete();
    for (int k = c + 1; k <= c + 5 && k < MAXC; k++) begin
      e_push[k] = 0; e_pop[k] = 0; e_redir[k] = 0;
    end
    mdl_on = 1'b1;
  endtask

  // Command accepted in cycle t: schedule what the outputs must show afterwards.
  task automatic mdl_accept(input int t);
    logic [31:0] tk, nt;
    logic [71:0] ent;
    if (t + 4 >= MAXC) return;
    if (!cmd_op) begin
      tk = mdl_mask & cmd_pred;
      nt = mdl_mask & ~cmd_pred;
      if (mdl_stk.size() >= DEPTH) begin
        ov_cyc    = imin(ov_cyc, t + 1);
        ready_cyc = t + 1;
      end else begin
        ent = {8'h00, 32'h0, mdl_mask};
        e_push[t+1] = 1; e_pdat[t+1] = ent;
        mdl_stk.push_back(ent);
        if (tk != 0 && nt != 0) begin
          ready_cyc = t + 3;
          if (mdl_stk.size() >= DEPTH) begin
            ov_cyc = imin(ov_cyc, t + 2);
          end else begin
            ent = {8'h80, cmd_pc + 32'd4, nt};
            e_push[t+2] = 1; e_pdat[t+2] = ent;
            mdl_stk.push_back(ent);
            upd_cyc = t + 3; upd_val = tk;
          end
        end else begin
          ready_cyc = t + 2;
        end
      end
    end else begin
      if (mdl_stk.size() == 0) begin
        un_cyc    = imin(un_cyc, t + 1);
        ready_cyc = t + 1;
      end else begin
        ent = mdl_stk.pop_back();
        e_pop[t+1] = 1;
        upd_cyc = t + 3; upd_val = ent[31:0];
        if (ent[71]) begin
          e_redir[t+3] = 1; e_rpc[t+3] = ent[63:32];
        end
        ready_cyc = t + 3;
      end
    end
  endtask

  // Per-cycle compare against the model, then the stack emulator, then command capture.
  always @(negedge clk) begin
    if (mdl_on && cyc < MAXC) begin
      if (upd_cyc == cyc) mdl_mask = upd_val;
      chk("active_mask", active_mask, mdl_mask);
      chk("cmd_ready", cmd_ready, cyc >= ready_cyc);
      chk("stk_push", stk_push, e_push[cyc]);
      if (stk_push && e_push[cyc]) chk("stk_data", stk_data, e_pdat[cyc]);
      chk("stk_pop", stk_pop, e_pop[cyc]);
      chk("redirect_valid", redirect_valid, e_redir[cyc]);
      if (redirect_valid && e_redir[cyc]) chk("redirect_pc", redirect_pc, e_rpc[cyc]);
      chk("err_overflow", err_overflow, cyc >= ov_cyc);
      chk("err_underflow", err_underflow, cyc >= un_cyc);
      chk("side_strobes", {stk_push_back, stk_read_tos}, 2'b00);
    end
    stk_data_vld = vld_pend;
    stk_data_out = pend_dat;
    vld_pend = 1'b0;
    if (stk_pop) begin
      pop_cnt++;
      pend_dat = (emu_q.size() > 0) ? emu_q.pop_back() : 72'd0;
      vld_pend = 1'b1;
    end
    if (stk_push) begin
      push_log.push_back(stk_data);
      if (emu_q.size() < DEPTH) emu_q.push_back(stk_data);
    end
    if (!rst_n) begin
      emu_q.delete();
      vld_pend = 1'b0;
      mdl_reset(cyc);
    end else if (mdl_on && cmd_valid && cmd_ready) begin
      mdl_accept(cyc);
    end
    stk_full  = (emu_q.size() >= DEPTH);
    stk_empty = (emu_q.size() == 0);
    cyc++;
  end

  // ---------------- directed helpers ----------------
  task automatic send(input bit op, input logic [31:0] pc, input logic [31:0] pred, output bit ok);
    bit got;
    got = 0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_pc = pc; cmd_pred = pred;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    ok = got;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: cmd_ready never high, expected 1");
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++; ok = 0;
      $display("FAIL done_timeout: cmd_ready stayed 0, expected 1");
    end
  endtask

  task automatic step(input string tag, input bit op, input logic [31:0] pc, input logic [31:0] pred,
                      input logic [31:0] emask, input bit eredir, input logic [31:0] erpc,
                      input int enpush, input int enpop);
    int p0;
    bit ok;
    push_log.delete();
    p0 = pop_cnt;
    send(op, pc, pred, ok);
    if (ok) begin
      chk({tag, "_mask"}, active_mask, emask);
      chk({tag, "_redir"}, redirect_valid, eredir);
      if (eredir) chk({tag, "_rpc"}, redirect_pc, erpc);
      chk({tag, "_npush"}, push_log.size(), enpush);
      chk({tag, "_npop"}, pop_cnt - p0, enpop);
    end
  endtask

  task automatic chk_push(input string tag, input int idx, input logic [71:0] exp);
    if (push_log.size() > idx) chk(tag, push_log[idx], exp);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL %s: push %0d missing, expected %h", tag, idx, exp);
    end
  endtask

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok, acc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mask", active_mask, 32'hFFFFFFFF);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_strobes", {stk_push, stk_pop, stk_push_back, stk_read_tos, redirect_valid}, 5'd0);
    chk("rst_errs", {err_overflow, err_underflow}, 2'b00);

    step("nd_split", 0, 32'h100, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0);
    chk_push("nd_push0", 0, 72'h00_00000000_FFFFFFFF);
    step("nd_join", 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    step("dv_split", 0, 32'h200, 32'h0000FFFF, 32'h0000FFFF, 0, 0, 2, 0);
    chk_push("dv_push0", 0, 72'h00_00000000_FFFFFFFF);
    chk_push("dv_push1", 1, 72'h80_00000204_FFFF0000);
    step("dv_join1", 1, 0, 0, 32'hFFFF0000, 1, 32'h204, 0, 1);
    step("dv_join2", 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    step("ns_split1", 0, 32'h300, 32'h0000FFFF, 32'h0000FFFF, 0, 0, 2, 0);
    step("ns_split2", 0, 32'h400, 32'h000000FF, 32'h000000FF, 0, 0, 2, 0);
    step("ns_join1", 1, 0, 0, 32'h0000FF00, 1, 32'h404, 0, 1);
    step("ns_join2", 1, 0, 0, 32'h0000FFFF, 0, 0, 0, 1);
    step("ns_join3", 1, 0, 0, 32'hFFFF0000, 1, 32'h304, 0, 1);
    step("ns_join4", 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    step("uf_join", 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("uf_flag", {err_overflow, err_underflow}, 2'b01);

    for (int i = 0; i < DEPTH; i++) step("fill", 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0);
    step("of_split", 0, 32'h600, 32'h0000FFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("of_flag", {err_overflow, err_underflow}, 2'b11);

    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_errs", {err_overflow, err_underflow}, 2'b00);
    step("wrap_split", 0, 32'hFFFFFFFC, 32'h0000FFFF, 32'h0000FFFF, 0, 0, 2, 0);
    chk_push("wrap_push1", 1, 72'h80_00000000_FFFF0000);

    // Reset while the controller sits in PUSH_DIV.
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_pc = 32'h500; cmd_pred = 32'h000000FF;
    @(negedge clk);
    chk("rpd_accept", cmd_ready, 1'b1);
    @(posedge clk); #2;
    cmd_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rpd_push", stk_push, 1'b0);
    chk("rpd_mask", active_mask, 32'hFFFFFFFF);
    chk("rpd_ready", cmd_ready, 1'b1);
    chk("rpd_errs", {err_overflow, err_underflow}, 2'b00);

    // Randomized traffic; the per-cycle model does all the checking here.
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready && rst_n;
      @(posedge clk); #2;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      if (!cmd_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          cmd_valid = 1'b1;
          cmd_op    = ($urandom_range(0, 99) < 45);
          cmd_pc    = $urandom & 32'hFFFFFFFC;
          case ($urandom_range(0, 3))
            0:       cmd_pred = '1;
            1:       cmd_pred = '0;
            default: cmd_pred = $urandom;
          endcase
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #2 cmd_valid = 1'b0; rst_n = 1'b1;
    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
